wr_flag_gen: RTL and testbench

WR_FLAG_GEN -- requirements
Module: wr_flag_gen

---
 rtl/wr_flag_gen.sv | 99 +++++++++
 tb/tb_wr_flag_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wr_flag_gen.sv
`default_nettype none
// ============================================================================
// Module      : wr_flag_gen
// Description : Write-side flag generator for an async FIFO. Synchronizes the
//               read gray pointer into the write clock domain and registers
//               the full flag. With WR_FLAG_GEN_ALMOST_FULL_EN defined it also
//               registers a fill level and an almost_full flag.
// Macro       : WR_FLAG_GEN_ALMOST_FULL_EN (enables o_level / o_almost_full)
// Revision    : 1.0 - initial release
// ============================================================================
module wr_flag_gen #(
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int AF_THRESH   = DEPTH / 2 - 1,
   localparam int PW         = $clog2(DEPTH)
) (
   input  logic          i_clock,
   input  logic          i_resetn,
   input  logic [PW-1:0] i_wr_ptr_next,
   input  logic [PW-1:0] i_rd_ptr,
`ifdef WR_FLAG_GEN_ALMOST_FULL_EN
   output logic [PW-1:0] o_level,
   output logic          o_almost_full,
`endif
   output logic          o_full
);

   // Synchronizer chain; stage 0 samples i_rd_ptr directly with no logic in front.
   logic [PW-1:0] r_rptr_sync [SYNC_STAGES];
   logic [PW-1:0] w_rptr_sync;
   logic          w_full_next;

   assign w_rptr_sync = r_rptr_sync[SYNC_STAGES-1];

   // Full when the write pointer leads the read pointer by exactly half the
   // gray range: in reflected gray code that is the two MSBs inverted.
   assign w_full_next = (i_wr_ptr_next == {~w_rptr_sync[PW-1:PW-2], w_rptr_sync[PW-3:0]});

   // Read pointer synchronizer; reset discards whatever is in flight.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_rptr_sync[i] <= '0;
         end
      end else begin
         r_rptr_sync[0] <= i_rd_ptr;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_rptr_sync[i] <= r_rptr_sync[i-1];
         end
      end
   end

   // Full flag register; drops only once the synchronized read pointer shows space.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         o_full <= 1'b0;
      end else begin
         o_full <= w_full_next;
      end
   end

`ifdef WR_FLAG_GEN_ALMOST_FULL_EN
   localparam logic [PW-1:0] c_af_thresh = PW'(AF_THRESH);

   logic [PW-1:0] w_wr_bin;
   logic [PW-1:0] w_rd_bin;
   logic [PW-1:0] w_level_next;
   logic          w_af_next;

   // Reflected gray to binary: each bit is the XOR of all gray bits at or above it.
   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign w_wr_bin     = gray2bin(i_wr_ptr_next);
   assign w_rd_bin     = gray2bin(w_rptr_sync);
   // PW-bit subtraction wraps naturally, giving the modulo-DEPTH distance.
   assign w_level_next = w_wr_bin - w_rd_bin;
   assign w_af_next    = (w_level_next >= c_af_thresh);

   // Level and almost_full registers, updated from the same values as full.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         o_level       <= '0;
         o_almost_full <= 1'b0;
      end else begin
         o_level       <= w_level_next;
         o_almost_full <= w_af_next;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wr_flag_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_flag_gen
// Description : Self-checking bench for wr_flag_gen (DEPTH=8, SYNC_STAGES=2,
//               AF_THRESH=3). Level/almost_full checks are active when
//               WR_FLAG_GEN_ALMOST_FULL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_flag_gen;
   localparam int DEPTH = 8;
   localparam int SYNC  = 2;
   localparam int AF    = 3;
   localparam int PW    = 3;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic [PW-1:0] wr_g;
   logic [PW-1:0] rd_g;
   logic          full;
`ifdef WR_FLAG_GEN_ALMOST_FULL_EN
   logic [PW-1:0] level;
   logic          almost_full;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Binary pointer state driven by the stimulus (always kept in 0..DEPTH-1).
   int wr_b = 0;
   int rd_b = 0;

   function automatic logic [PW-1:0] to_gray(input int b);
      logic [PW-1:0] v;
      v = PW'(b);
      return v ^ (v >> 1);
   endfunction

   assign wr_g = to_gray(wr_b);
   assign rd_g = to_gray(rd_b);

   always #5 clk = ~clk;

   wr_flag_gen #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC),
      .AF_THRESH   (AF)
   ) u_dut (
      .i_clock       (clk),
      .i_resetn      (rst_n),
      .i_wr_ptr_next (wr_g),
      .i_rd_ptr      (rd_g),
`ifdef WR_FLAG_GEN_ALMOST_FULL_EN
      .o_level       (level),
      .o_almost_full (almost_full),
`endif
      .o_full        (full)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Reference model: the read pointer seen by the flag logic is the value the
   // read side presented SYNC edges ago (zero after reset); fill level is the
   // binary distance modulo DEPTH, full at exactly DEPTH/2.
   int rd_hist[$];
   int m_lvl;
   int exp_level = 0;
   bit exp_full  = 1'b0;
   bit exp_af    = 1'b0;
   bit chk_en    = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_hist = {};
         repeat (SYNC) rd_hist.push_back(0);
         exp_level = 0;
         exp_full  = 1'b0;
         exp_af    = 1'b0;
      end else begin
         m_lvl     = (wr_b - rd_hist[0] + DEPTH) % DEPTH;
         exp_level = m_lvl;
         exp_full  = (m_lvl == DEPTH / 2);
         exp_af    = (m_lvl >= AF);
         void'(rd_hist.pop_front());
         rd_hist.push_back(rd_b);
      end
   end

   // Per-cycle comparison against the model, sampled away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_full", 32'(full), 32'(exp_full));
`ifdef WR_FLAG_GEN_ALMOST_FULL_EN
         chk("model_level", 32'(level), 32'(exp_level));
         chk("model_af", 32'(almost_full), 32'(exp_af));
`endif
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic lit(input string nm, input bit f, input int lv, input bit a);
      chk({nm, "_full"}, 32'(full), 32'(f));
`ifdef WR_FLAG_GEN_ALMOST_FULL_EN
      chk({nm, "_level"}, 32'(level), 32'(lv));
      chk({nm, "_af"}, 32'(almost_full), 32'(a));
`endif
   endtask

   initial begin
      // Reset state
      #1 rst_n = 1'b0;
      wr_b = 0;
      rd_b = 0;
      tick();
      tick();
      lit("reset", 1'b0, 0, 1'b0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Fill to full with read pointer parked at 0
      wr_b = 1; tick();
      wr_b = 2; tick();
      wr_b = 3; tick();
      lit("fill3", 1'b0, 3, 1'b1);
      wr_b = 4; tick();
      lit("fill4", 1'b1, 4, 1'b1);

      // Read-side latency: full drops exactly on the third edge
      rd_b = 1; tick();
      lit("rd_lat1", 1'b1, 4, 1'b1);
      tick();
      lit("rd_lat2", 1'b1, 4, 1'b1);
      tick();
      lit("rd_lat3", 1'b0, 3, 1'b1);

      // Back to full, then asynchronous reset between edges
      wr_b = 5; tick();
      lit("refill", 1'b1, 4, 1'b1);
      #2 rst_n = 1'b0;
      #1 lit("async_rst", 1'b0, 0, 1'b0);
      wr_b = 0;
      rd_b = 0;
      tick();
      rst_n = 1'b1;

      // Write and synchronized read pointer change on the same edge
      wr_b = 3; tick(); tick();
      rd_b = 1; tick();
      tick();
      lit("same_pre", 1'b0, 3, 1'b1);
      wr_b = 4; tick();
      lit("same_edge", 1'b0, 3, 1'b1);

      // Random traffic with wrap-around and occasional mid-run resets
      for (int c = 0; c < 600; c++) begin
         if ((((wr_b - rd_b + DEPTH) % DEPTH) < DEPTH / 2) && ($urandom_range(0, 2) != 0))
            wr_b = (wr_b + 1) % DEPTH;
         if ((wr_b != rd_b) && ($urandom_range(0, 2) != 0))
            rd_b = (rd_b + 1) % DEPTH;
         tick();
         if ($urandom_range(0, 149) == 0) begin
            #2 rst_n = 1'b0;
            #1 lit("rand_rst", 1'b0, 0, 1'b0);
            wr_b = 0;
            rd_b = 0;
            tick();
            rst_n = 1'b1;
         end
      end

      chk_en = 1'b0;
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
